// File: rtl/dmi_jtag_dtm_if.sv
// DMI link between the JTAG DTM (master, issues requests) and the debug module (slave).
interface dmi_jtag_dtm_if #(
  parameter int ABITS = 7
);
  logic             oDmiReqValid;
  logic             iDmiReqReady;
  logic [ABITS-1:0] oDmiAddr;
  logic [31:0]      oDmiData;
  logic [1:0]       oDmiOp;
  logic             iDmiRspValid;
  logic             oDmiRspReady;
  logic [31:0]      iDmiRspData;
  logic [1:0]       iDmiRspOp;

  modport master (
    output oDmiReqValid, oDmiAddr, oDmiData, oDmiOp, oDmiRspReady,
    input  iDmiReqReady, iDmiRspValid, iDmiRspData, iDmiRspOp
  );

  modport slave (
    input  oDmiReqValid, oDmiAddr, oDmiData, oDmiOp, oDmiRspReady,
    output iDmiReqReady, iDmiRspValid, iDmiRspData, iDmiRspOp
  );
endinterface

// File: rtl/dmi_jtag_dtm.sv
// RISC-V JTAG DTM: oversampled 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS registers,
// turning DMI scans into valid/ready requests on the DMI link.
module dmi_jtag_dtm #(
  parameter logic [31:0] IDCODE    = 32'h1000_0001,
  parameter int          ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic iClk,
  input  logic nRst,
  input  logic iTCK,
  input  logic iTMS,
  input  logic iTDI,
  output logic oTDO,
  output logic oTDOEn,
  dmi_jtag_dtm_if.master dmi
);
  localparam int DRW = ABITS + 34;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e state_reg, state_next;

  // Two-flop synchronizers for {TDI, TMS, TCK}.
  logic [2:0] pins, pin_s1, pin_s2;
  logic       tck_q, tck_rise, tck_fall, tms_s, tdi_s;
  assign pins = {iTDI, iTMS, iTCK};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
          pin_s1[gi] <= 1'b0;
          pin_s2[gi] <= 1'b0;
        end else begin
          pin_s1[gi] <= pins[gi];
          pin_s2[gi] <= pin_s1[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) tck_q <= 1'b0;
    else       tck_q <= pin_s2[0];
  end

  assign tck_rise = pin_s2[0] & ~tck_q;
  assign tck_fall = ~pin_s2[0] & tck_q;
  assign tms_s    = pin_s2[1];
  assign tdi_s    = pin_s2[2];

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst)         state_reg <= TLR;
    else if (tck_rise) state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      TLR:    state_next = tms_s ? TLR    : RTI;
      RTI:    state_next = tms_s ? SEL_DR : RTI;
      SEL_DR: state_next = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms_s ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms_s ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms_s ? UPD_DR : PAU_DR;
      PAU_DR: state_next = tms_s ? EX2_DR : PAU_DR;
      EX2_DR: state_next = tms_s ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms_s ? SEL_DR : RTI;
      SEL_IR: state_next = tms_s ? TLR    : CAP_IR;
      CAP_IR: state_next = tms_s ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms_s ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms_s ? UPD_IR : PAU_IR;
      PAU_IR: state_next = tms_s ? EX2_IR : PAU_IR;
      EX2_IR: state_next = tms_s ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms_s ? SEL_DR : RTI;
    endcase
  end

  // Instruction register
  logic [4:0] ir_reg, ir_sr;
  logic       sel_idcode, sel_dtmcs, sel_dmi;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      ir_reg <= 5'h01;
      ir_sr  <= 5'h00;
    end else if (tck_rise) begin
      if (state_next == TLR)          ir_reg <= 5'h01;
      else if (state_reg == UPD_IR)   ir_reg <= ir_sr;
      if (state_reg == CAP_IR)        ir_sr <= 5'b00001;
      else if (state_reg == SH_IR)    ir_sr <= {tdi_s, ir_sr[4:1]};
    end
  end

  assign sel_idcode = (ir_reg == 5'h01);
  assign sel_dtmcs  = (ir_reg == 5'h10);
  assign sel_dmi    = (ir_reg == 5'h11);

  // DMI bookkeeping state
  logic [1:0]       stat_reg, stat_next, cap_status;
  logic             inflight_reg, inflight_next, discard_reg, discard_next;
  logic [ABITS-1:0] last_addr_reg, last_addr_next;
  logic [31:0]      last_rdata_reg, last_rdata_next;
  logic             req_valid_reg, req_valid_next;
  logic [ABITS-1:0] req_addr_reg, req_addr_next;
  logic [31:0]      req_data_reg, req_data_next;
  logic [1:0]       req_op_reg, req_op_next;
  logic [DRW-1:0]   dr_sr;
  logic [1:0]       dr_op;
  logic [31:0]      dtmcs_val;

  assign dr_op     = dr_sr[1:0];
  assign dtmcs_val = {14'd0, 2'b00, 1'b0, IDLE_HINT, stat_reg, 6'(ABITS), 4'd1};

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      dr_sr <= '0;
    end else if (tck_rise) begin
      if (state_reg == CAP_DR) begin
        if (sel_idcode)     dr_sr <= DRW'(IDCODE);
        else if (sel_dtmcs) dr_sr <= DRW'(dtmcs_val);
        else if (sel_dmi)   dr_sr <= {last_addr_reg, last_rdata_next, cap_status};
        else                dr_sr <= '0;
      end else if (state_reg == SH_DR) begin
        if (sel_dmi)                    dr_sr <= {tdi_s, dr_sr[DRW-1:1]};
        else if (sel_idcode || sel_dtmcs) dr_sr[31:0] <= {tdi_s, dr_sr[31:1]};
        else                            dr_sr[0] <= tdi_s;
      end
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst)         oTDO <= 1'b0;
    else if (tck_fall) oTDO <= (state_reg == SH_IR) ? ir_sr[0] : dr_sr[0];
  end

  assign oTDOEn = (state_reg == SH_DR) || (state_reg == SH_IR);

  // Responses are folded in before any capture/update of the same cycle.
  always_comb begin
    stat_next       = stat_reg;
    inflight_next   = inflight_reg;
    discard_next    = discard_reg;
    last_addr_next  = last_addr_reg;
    last_rdata_next = last_rdata_reg;
    req_valid_next  = req_valid_reg;
    req_addr_next   = req_addr_reg;
    req_data_next   = req_data_reg;
    req_op_next     = req_op_reg;

    if (req_valid_reg && dmi.iDmiReqReady) req_valid_next = 1'b0;

    if (dmi.iDmiRspValid) begin
      if (!inflight_reg || discard_reg) begin
        discard_next = 1'b0;
      end else begin
        inflight_next = 1'b0;
        if (req_op_reg == OP_READ) last_rdata_next = dmi.iDmiRspData;
        if (stat_reg == 2'd0 && (dmi.iDmiRspOp == 2'd2 || dmi.iDmiRspOp == 2'd3))
          stat_next = dmi.iDmiRspOp;
      end
    end

    cap_status = inflight_next ? 2'd3 : stat_next;

    if (tck_rise && sel_dmi) begin
      if (state_reg == CAP_DR && inflight_next) stat_next = 2'd3;
      if (state_reg == UPD_DR && (dr_op == OP_READ || dr_op == OP_WRITE)) begin
        if (inflight_next) begin
          stat_next = 2'd3;
        end else if (stat_next == 2'd0) begin
          req_valid_next = 1'b1;
          req_addr_next  = dr_sr[DRW-1:34];
          req_data_next  = dr_sr[33:2];
          req_op_next    = dr_op;
          inflight_next  = 1'b1;
          last_addr_next = dr_sr[DRW-1:34];
        end
      end
    end

    if (tck_rise && sel_dtmcs && state_reg == UPD_DR) begin
      if (dr_sr[16]) stat_next = 2'd0;
      if (dr_sr[17]) begin
        stat_next      = 2'd0;
        req_valid_next = 1'b0;
        inflight_next  = 1'b0;
        discard_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      stat_reg       <= 2'd0;
      inflight_reg   <= 1'b0;
      discard_reg    <= 1'b0;
      last_addr_reg  <= '0;
      last_rdata_reg <= '0;
      req_valid_reg  <= 1'b0;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      req_op_reg     <= 2'd0;
    end else begin
      stat_reg       <= stat_next;
      inflight_reg   <= inflight_next;
      discard_reg    <= discard_next;
      last_addr_reg  <= last_addr_next;
      last_rdata_reg <= last_rdata_next;
      req_valid_reg  <= req_valid_next;
      req_addr_reg   <= req_addr_next;
      req_data_reg   <= req_data_next;
      req_op_reg     <= req_op_next;
    end
  end

  assign dmi.oDmiReqValid = req_valid_reg;
  assign dmi.oDmiAddr     = req_addr_reg;
  assign dmi.oDmiData     = req_data_reg;
  assign dmi.oDmiOp       = req_op_reg;
  assign dmi.oDmiRspReady = 1'b1;
endmodule
